ysyx_lsu: RTL and testbench
===========================

YSYX_LSU -- requirements
Module: ysyx_LSU

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clock `clk`, reset `rst`.
REQ-002 Ports, in order (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  load/store request present
- req_ready  out  1  LSU can accept a request
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bytes significant)
- dm_rd_sel  in  3  load type: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw
- dm_wr_sel  in  2  store type: 00 none, 01 sb, 10 sh, 11 sw
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_rdata  out  32  extended load data; 0 for stores, no-ops and errors
- resp_err  out  1  misaligned access or illegal select
- mem_valid  out  1  memory request
- mem_ready  in  1  memory accepts request
- mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
- mem_wen  out  1  1 = write, 0 = read
- mem_wdata  out  32  lane-replicated store data
- mem_wmask  out  4  byte enables; 0000 on reads
- mem_rvalid  in  1  memory read data or write ack valid
- mem_rdata  in  32  memory read word

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, WAIT, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid & req_ready.
REQ-005 On acceptance, addr[1:0], both selects and req_wdata SHALL be registered; later changes to the request inputs SHALL be ignored.
REQ-006 Error conditions: dm_rd_sel = 110/111; both selects nonzero; lh/lhu/sh with addr[0] = 1; lw/sw with addr[1:0] != 0.
REQ-007 Accept with an error, or with both selects zero, SHALL go IDLE->RESP with no memory access. resp_err = 1 for errors, 0 for a no-op.
REQ-008 Any other accept SHALL go IDLE->REQ.
REQ-009 In REQ, mem_valid SHALL be 1 with stable addr, wen, wdata and wmask until mem_ready; REQ->WAIT on mem_ready.
REQ-010 In WAIT, mem_valid SHALL be 0; WAIT->RESP on mem_rvalid, capturing mem_rdata. mem_rvalid outside WAIT SHALL be ignored.
REQ-011 Store lanes:
- sb: mem_wdata = {4{wdata[7:0]}}, mem_wmask = 0001 << addr[1:0]
- sh: mem_wdata = {2{wdata[15:0]}}, mem_wmask = 0011 << addr[1:0]
- sw: mem_wdata = wdata, mem_wmask = 1111
REQ-012 Load extraction: byte lane = mem_rdata[8*addr[1:0] +: 8]; half lane = mem_rdata[16*addr[1] +: 16]. lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
REQ-013 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until resp_ready; RESP->IDLE on resp_ready.
REQ-014 Zero-wait memory (mem_ready in the REQ cycle, mem_rvalid in the first WAIT cycle): accept at cycle T gives resp_valid at T+3. Error/no-op accept at T gives resp_valid at T+1.
REQ-015 Outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from mem_* inputs to resp_* outputs.
REQ-016 Next request acceptance SHALL occur no earlier than the cycle after RESP->IDLE (one outstanding transaction).

Reset
REQ-017 rst SHALL force IDLE and zero every output except req_ready, which is 1 after reset.
REQ-018 rst asserted in any state (including mid REQ/WAIT) SHALL abandon the transaction: mem_valid is 0 next cycle and no resp_valid is issued for it.

Verification
REQ-019 lb at addr 0x80000003, mem_rdata 0x80FF1234, zero-wait memory -> resp_rdata 0xFFFFFF80, resp_err 0, resp_valid at T+3.
REQ-020 sh at addr 0x80000002, wdata 0x0000BEEF -> mem_wen 1, mem_addr 0x80000000, mem_wdata 0xBEEFBEEF, mem_wmask 1100; resp_rdata 0.
REQ-021 lw at addr 0x80000006 -> resp_err 1 and resp_rdata 0 at T+1; mem_valid never asserted.
REQ-022 lhu at 0x80000002 with mem_ready held low 3 cycles and resp_ready low 2 cycles -> mem_* signals stable throughout; resp_rdata 0x0000ABCD (mem_rdata 0xABCD0000) held until resp_ready.
REQ-023 rst pulsed during WAIT, then mem_rvalid arrives -> no resp_valid; req_ready 1 the cycle after reset.
REQ-024 dm_rd_sel 001 with dm_wr_sel 11 -> resp_err 1 at T+1, no memory access.

Source files
------------

// File: rtl/ysyx_lsu.sv
// Load/store unit: one outstanding byte/half/word access over a valid/ready memory port.
// Store data is lane-replicated on the way out; load data is extracted and extended on the way back.
module ysyx_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  dm_rd_sel,
  input  logic [1:0]  dm_wr_sel,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_r;
  logic [1:0]  off_r;
  logic [2:0]  rd_sel_r;

  logic        err_s;
  logic        noop_s;
  logic [31:0] wdata_s;
  logic [3:0]  wmask_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] load_s;

  // Request decode: legality check and store lane replication
  always_comb begin
    err_s   = (dm_rd_sel == 3'b110) || (dm_rd_sel == 3'b111) ||
              ((dm_rd_sel != 3'b000) && (dm_wr_sel != 2'b00)) ||
              (((dm_rd_sel == 3'b011) || (dm_rd_sel == 3'b100) || (dm_wr_sel == 2'b10)) &&
               req_addr[0]) ||
              (((dm_rd_sel == 3'b101) || (dm_wr_sel == 2'b11)) && (req_addr[1:0] != 2'b00));
    noop_s  = (dm_rd_sel == 3'b000) && (dm_wr_sel == 2'b00);
    wdata_s = 32'h0000_0000;
    wmask_s = 4'b0000;
    case (dm_wr_sel)
      2'b01: begin
        wdata_s = {4{req_wdata[7:0]}};
        wmask_s = 4'b0001 << req_addr[1:0];
      end
      2'b10: begin
        wdata_s = {2{req_wdata[15:0]}};
        wmask_s = 4'b0011 << req_addr[1:0];
      end
      2'b11: begin
        wdata_s = req_wdata;
        wmask_s = 4'b1111;
      end
      default: begin
        wdata_s = 32'h0000_0000;
        wmask_s = 4'b0000;
      end
    endcase
  end

  // Load lane extraction and extension from the returning memory word
  always_comb begin
    byte_s = mem_rdata[{off_r, 3'b000} +: 8];
    half_s = mem_rdata[{off_r[1], 4'b0000} +: 16];
    load_s = 32'h0000_0000;
    case (rd_sel_r)
      3'b001:  load_s = {{24{byte_s[7]}}, byte_s};
      3'b010:  load_s = {24'h00_0000, byte_s};
      3'b011:  load_s = {{16{half_s[15]}}, half_s};
      3'b100:  load_s = {16'h0000, half_s};
      3'b101:  load_s = mem_rdata;
      default: load_s = 32'h0000_0000;
    endcase
  end

  // Transaction FSM; every port output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      off_r      <= 2'b00;
      rd_sel_r   <= 3'b000;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wen    <= 1'b0;
      mem_wdata  <= 32'h0000_0000;
      mem_wmask  <= 4'b0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            off_r     <= req_addr[1:0];
            rd_sel_r  <= dm_rd_sel;
            if (err_s || noop_s) begin
              state_r    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= err_s;
              resp_rdata <= 32'h0000_0000;
            end else begin
              state_r   <= S_REQ;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wen   <= (dm_wr_sel != 2'b00);
              mem_wdata <= wdata_s;
              mem_wmask <= wmask_s;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state_r   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Stores also finish here: their ack carries no data, and rd_sel_r is zero
          if (mem_rvalid) begin
            state_r    <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_s;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_r    <= S_IDLE;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          req_ready  <= 1'b1;
          mem_valid  <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Bench for ysyx_lsu: directed vector table, randomized transactions against an arithmetic
// model of the access rules, and hand-written reset-abort sequences.
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  dm_rd_sel;
  logic [1:0]  dm_wr_sel;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  ysyx_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .dm_rd_sel(dm_rd_sel), .dm_wr_sel(dm_wr_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic        mem;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } exp_t;

  typedef struct {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] addr, wdata, mword;
    int          mr, rv, rr;
    exp_t        e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  // observations of one transaction
  logic        o_err, o_mem, o_wen, o_unstable, o_rr_bad, o_timeout, o_end_ok;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_wmask;
  int          o_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] mword,
                                 input int mr, input int rv);
    exp_t e;
    int sz, off;
    logic [31:0] b, h;
    e.err = 1'b0; e.rdata = 32'h0; e.lat = 1; e.mem = 1'b0; e.wdata = 32'h0; e.wmask = 4'h0;
    sz = 1;
    if (rd == 3 || rd == 4 || wr == 2) sz = 2;
    if (rd == 5 || wr == 3) sz = 4;
    off = int'(addr % 4);
    if (rd > 5 || (rd != 0 && wr != 0) || (off % sz) != 0) e.err = 1'b1;
    if (!e.err && !(rd == 0 && wr == 0)) begin
      e.mem = 1'b1;
      e.lat = 3 + mr + rv;
      b = (mword >> (8 * off)) & 32'hFF;
      h = (mword >> (16 * (off / 2))) & 32'hFFFF;
      case (rd)
        3'd1: e.rdata = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
        3'd2: e.rdata = b;
        3'd3: e.rdata = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
        3'd4: e.rdata = h;
        3'd5: e.rdata = mword;
        default: e.rdata = 32'h0;
      endcase
      case (wr)
        2'd1: begin e.wdata = (wdata & 32'hFF) * 32'h0101_0101;   e.wmask = 4'b0001 << off; end
        2'd2: begin e.wdata = (wdata & 32'hFFFF) * 32'h0001_0001; e.wmask = 4'b0011 << off; end
        2'd3: begin e.wdata = wdata; e.wmask = 4'b1111; end
        default: begin e.wdata = 32'h0; e.wmask = 4'b0000; end
      endcase
    end
    return e;
  endfunction

  function automatic void add(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] mword, input int mr,
                              input int rv, input int rr, input logic err, input logic [31:0] rdata,
                              input int lat, input logic mem, input logic [31:0] ewd,
                              input logic [3:0] ewm);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mword = mword;
    v.mr = mr; v.rv = rv; v.rr = rr;
    v.e.err = err; v.e.rdata = rdata; v.e.lat = lat; v.e.mem = mem; v.e.wdata = ewd; v.e.wmask = ewm;
    tbl.push_back(v);
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; dm_rd_sel = 3'd0; dm_wr_sel = 2'd0;
    resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  // Runs one transaction from IDLE, acting as memory and consumer; called and returns at a negedge.
  task automatic run_txn(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mword,
                         input int mr, input int rv, input int rr);
    int mcnt, wcnt, rcnt;
    bit hs, hs_now, dlv, rdone, first_r, done;
    mcnt = 0; wcnt = 0; rcnt = 0; hs = 0; dlv = 0; rdone = 0; first_r = 0; done = 0;
    o_err = 1'b0; o_mem = 1'b0; o_wen = 1'b0; o_unstable = 1'b0; o_rr_bad = 1'b0;
    o_timeout = 1'b0; o_end_ok = 1'b0; o_rdata = 32'h0; o_addr = 32'h0; o_wdata = 32'h0;
    o_wmask = 4'h0; o_lat = -1;
    req_valid = 1'b1; dm_rd_sel = rd; dm_wr_sel = wr; req_addr = addr; req_wdata = wdata;
    mem_ready = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom; resp_ready = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= 60 && !done; c++) begin
      if (rdone) begin
        o_end_ok = !resp_valid && req_ready;
        done = 1;
      end else begin
        if (req_ready) o_rr_bad = 1'b1;
        if (mem_valid) begin
          if (hs) o_unstable = 1'b1;
          if (!o_mem) begin
            o_mem = 1'b1; o_addr = mem_addr; o_wen = mem_wen; o_wdata = mem_wdata; o_wmask = mem_wmask;
          end else if (mem_addr !== o_addr || mem_wen !== o_wen || mem_wdata !== o_wdata ||
                       mem_wmask !== o_wmask) begin
            o_unstable = 1'b1;
          end
        end
        if (resp_valid) begin
          if (!first_r) begin
            first_r = 1; o_lat = c; o_rdata = resp_rdata; o_err = resp_err;
          end else if (resp_rdata !== o_rdata || resp_err !== o_err) begin
            o_unstable = 1'b1;
          end
        end
        // request inputs scrambled after acceptance; they must be ignored
        req_addr = $urandom; req_wdata = $urandom;
        dm_rd_sel = 3'($urandom); dm_wr_sel = 2'($urandom); req_valid = 1'($urandom_range(0, 1));
        hs_now = 0;
        if (mem_valid && !hs) begin
          if (mcnt >= mr) begin mem_ready = 1'b1; hs = 1; hs_now = 1; end
          else begin mem_ready = 1'b0; mcnt++; end
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        if (hs && !hs_now && !dlv) begin
          if (wcnt >= rv) begin mem_rvalid = 1'b1; mem_rdata = mword; dlv = 1; end
          else begin mem_rvalid = 1'b0; mem_rdata = $urandom; wcnt++; end
        end else begin
          mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        end
        if (resp_valid) begin
          if (rcnt >= rr) begin resp_ready = 1'b1; rdone = 1; req_valid = 1'b0; end
          else begin resp_ready = 1'b0; rcnt++; end
        end else begin
          resp_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
      end
    end
    if (!done) o_timeout = 1'b1;
    idle_inputs();
    if (!done) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end
  endtask

  task automatic check_txn(input string tag, input logic [31:0] addr, input logic [1:0] wr,
                           input exp_t e);
    chk({tag, "_timeout"}, 32'(o_timeout), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'(e.err));
    chk({tag, "_rdata"}, o_rdata, e.rdata);
    chk({tag, "_latency"}, 32'(o_lat), 32'(e.lat));
    chk({tag, "_mem_access"}, 32'(o_mem), 32'(e.mem));
    chk({tag, "_stable"}, 32'(o_unstable), 32'd0);
    chk({tag, "_req_ready_busy"}, 32'(o_rr_bad), 32'd0);
    chk({tag, "_back_to_idle"}, 32'(o_end_ok), 32'd1);
    if (e.mem) begin
      chk({tag, "_mem_addr"}, o_addr, addr & 32'hFFFF_FFFC);
      chk({tag, "_mem_wen"}, 32'(o_wen), 32'(wr != 2'd0));
      chk({tag, "_mem_wdata"}, o_wdata, e.wdata);
      chk({tag, "_mem_wmask"}, 32'(o_wmask), 32'(e.wmask));
    end
  endtask

  initial begin
    logic [2:0] rd;
    logic [1:0] wr;
    logic [31:0] a, wd, mw;
    int mr, rv, rr, r, seen;
    exp_t e;

    //   rd    wr    addr          wdata         mword         mr rv rr err   rdata         lat mem   wdata         wmask
    add(3'd1, 2'd0, 32'h8000_0003, 32'h0,        32'h80FF_1234, 0, 0, 0, 1'b0, 32'hFFFF_FF80, 3, 1'b1, 32'h0,        4'b0000);
    add(3'd0, 2'd2, 32'h8000_0002, 32'h0000_BEEF, 32'h0,        0, 0, 0, 1'b0, 32'h0,        3, 1'b1, 32'hBEEF_BEEF, 4'b1100);
    add(3'd5, 2'd0, 32'h8000_0006, 32'h0,        32'h0,         0, 0, 0, 1'b1, 32'h0,        1, 1'b0, 32'h0,        4'b0000);
    add(3'd4, 2'd0, 32'h8000_0002, 32'h0,        32'hABCD_0000, 3, 0, 2, 1'b0, 32'h0000_ABCD, 6, 1'b1, 32'h0,        4'b0000);
    add(3'd1, 2'd3, 32'h8000_0000, 32'h0,        32'h0,         0, 0, 0, 1'b1, 32'h0,        1, 1'b0, 32'h0,        4'b0000);
    add(3'd0, 2'd0, 32'h8000_0001, 32'h1234_5678, 32'h0,        0, 0, 1, 1'b0, 32'h0,        1, 1'b0, 32'h0,        4'b0000);
    add(3'd1, 2'd0, 32'h8000_0001, 32'h0,        32'h0000_7F00, 0, 0, 0, 1'b0, 32'h0000_007F, 3, 1'b1, 32'h0,        4'b0000);
    add(3'd3, 2'd0, 32'h8000_0002, 32'h0,        32'h8001_0000, 0, 0, 0, 1'b0, 32'hFFFF_8001, 3, 1'b1, 32'h0,        4'b0000);
    add(3'd2, 2'd0, 32'h8000_0000, 32'h0,        32'h0000_00F0, 0, 2, 0, 1'b0, 32'h0000_00F0, 5, 1'b1, 32'h0,        4'b0000);
    add(3'd0, 2'd1, 32'h8000_0001, 32'h1234_56A5, 32'h0,        0, 0, 0, 1'b0, 32'h0,        3, 1'b1, 32'hA5A5_A5A5, 4'b0010);
    add(3'd0, 2'd3, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0,        1, 2, 0, 1'b0, 32'h0,        6, 1'b1, 32'hDEAD_BEEF, 4'b1111);
    add(3'd6, 2'd0, 32'h8000_0000, 32'h0,        32'h0,         0, 0, 0, 1'b1, 32'h0,        1, 1'b0, 32'h0,        4'b0000);
    add(3'd0, 2'd2, 32'h8000_0001, 32'h0,        32'h0,         0, 0, 0, 1'b1, 32'h0,        1, 1'b0, 32'h0,        4'b0000);
    add(3'd5, 2'd0, 32'h8000_0004, 32'h0,        32'h1234_5678, 0, 1, 0, 1'b0, 32'h1234_5678, 4, 1'b1, 32'h0,        4'b0000);
    add(3'd4, 2'd0, 32'h8000_0003, 32'h0,        32'h0,         0, 0, 0, 1'b1, 32'h0,        1, 1'b0, 32'h0,        4'b0000);
    add(3'd2, 2'd0, 32'h8000_0003, 32'h0,        32'hF000_0000, 0, 0, 0, 1'b0, 32'h0000_00F0, 3, 1'b1, 32'h0,        4'b0000);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_resp_err", 32'(resp_err), 32'd0);
    chk("reset_mem_valid", 32'(mem_valid), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wen", 32'(mem_wen), 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_mem_wmask", 32'(mem_wmask), 32'd0);

    foreach (tbl[i]) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mword, tbl[i].mr, tbl[i].rv, tbl[i].rr);
      check_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wr, tbl[i].e);
    end

    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin rd = 3'($urandom_range(1, 5)); wr = 2'd0; end
      else if (r < 7) begin rd = 3'd0; wr = 2'($urandom_range(1, 3)); end
      else begin rd = 3'($urandom); wr = 2'($urandom); end
      a = $urandom; wd = $urandom; mw = $urandom;
      mr = $urandom_range(0, 3); rv = $urandom_range(0, 3); rr = $urandom_range(0, 3);
      e = model(rd, wr, a, wd, mw, mr, rv);
      run_txn(rd, wr, a, wd, mw, mr, rv, rr);
      check_txn($sformatf("rnd%0d", k), a, wr, e);
    end

    // reset while waiting for read data: the late data must not produce a response
    req_valid = 1'b1; dm_rd_sel = 3'd5; dm_wr_sel = 2'd0; req_addr = 32'h8000_0010;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    chk("rstwait_mem_valid_req", 32'(mem_valid), 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("rstwait_mem_valid_wait", 32'(mem_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait_req_ready", 32'(req_ready), 32'd1);
    chk("rstwait_resp_valid", 32'(resp_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (resp_valid || mem_valid || !req_ready) seen++;
    end
    chk("rstwait_no_response", 32'(seen), 32'd0);

    // reset while the memory request is pending
    req_valid = 1'b1; dm_rd_sel = 3'd0; dm_wr_sel = 2'd3; req_addr = 32'h8000_0020; req_wdata = 32'h1111_2222;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstreq_mem_valid_before", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstreq_mem_valid_after", 32'(mem_valid), 32'd0);
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid || mem_valid) seen++;
    end
    idle_inputs();
    chk("rstreq_no_activity", 32'(seen), 32'd0);

    // reset while an error response is waiting for the consumer
    req_valid = 1'b1; dm_rd_sel = 3'd7; dm_wr_sel = 2'd0; req_addr = 32'h8000_0000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstresp_valid_before", 32'(resp_valid), 32'd1);
    chk("rstresp_err_before", 32'(resp_err), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstresp_valid_after", 32'(resp_valid), 32'd0);
    chk("rstresp_err_after", 32'(resp_err), 32'd0);
    chk("rstresp_req_ready", 32'(req_ready), 32'd1);

    // a normal transaction still completes after the aborts
    run_txn(3'd1, 2'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
    check_txn("post_reset", 32'h8000_0003, 2'd0, model(3'd1, 2'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
